mem_req_sched: RTL and testbench

- Host-facing request scheduler that sits directly upstream of the SDRAM-style memory controller.
- Buffers host read/write requests in a small FIFO and issues them one at a time on the controller's cmd_n/RDnWR/Addr_in/Data_in interface.
- Holds every controller input stable until the controller's command output acknowledges the request.
- Returns one response per request (read data or write ack) to the host.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_req_fifo.sv | 53 +++++
 rtl/mem_req_sched.sv | 199 +++++++++++++++++++
 tb/tb_mem_req_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the host request scheduler and its request FIFO.
package mem_ctrl_pkg;

  localparam int unsigned ReqAw = 16;
  localparam int unsigned ReqDw = 32;

  typedef enum logic [2:0] {
    CmdNop     = 3'd0,
    CmdAct     = 3'd1,
    CmdRead    = 3'd2,
    CmdWrite   = 3'd3,
    CmdPre     = 3'd4,
    CmdRefresh = 3'd5
  } cmd_t;

  typedef struct packed {
    logic             rnw;
    logic [ReqAw-1:0] addr;
    logic [ReqDw-1:0] wdata;
  } mem_req_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWrWait,
    StRdWait,
    StRdCapt,
    StResp
  } sched_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; pointers carry a wrap bit to tell full from empty.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  mem_req_t push_data_i,
  input  logic     pop_i,
  output mem_req_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  mem_req_t      mem_q [Depth];
  logic          do_push, do_pop;

  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mem_req_sched.sv
// Host request scheduler: queues requests and issues them one at a time to the memory controller.
// Optional MEM_REQ_TIMEOUT_EN aborts a request that waits TIMEOUT_CYC cycles on the controller.
module mem_req_sched
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_rnw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_vld,
  output logic          rsp_rnw,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mc_cmd_n,
  output logic          mc_rdnwr,
  output logic [AW-1:0] mc_addr,
  output logic          mc_data_in_vld,
  output logic [DW-1:0] mc_data_in,
  input  logic [2:0]    mc_command,
  input  logic          mc_data_out_vld,
  input  logic [DW-1:0] mc_data_out
);

  sched_state_t  state_q, state_d;
  logic          rdy_en_q;
  logic          req_rnw_q, req_rnw_d;
  logic          mc_cmd_n_q, mc_cmd_n_d;
  logic          mc_rdnwr_q, mc_rdnwr_d;
  logic [AW-1:0] mc_addr_q, mc_addr_d;
  logic          mc_data_in_vld_q, mc_data_in_vld_d;
  logic [DW-1:0] mc_data_in_q, mc_data_in_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_rnw_q, rsp_rnw_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          fifo_full, fifo_empty, fifo_pop;
  mem_req_t      fifo_in, fifo_head;
  cmd_t          cmd;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
`endif

  assign cmd     = cmd_t'(mc_command);
  // rdy_en_q keeps req_rdy low while reset is held and for the first edge after.
  assign req_rdy = rdy_en_q && !fifo_full;
  assign fifo_in = '{rnw: req_rnw, addr: req_addr, wdata: req_wdata};

  mem_req_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (req_vld && req_rdy),
    .push_data_i(fifo_in),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d          = state_q;
    req_rnw_d        = req_rnw_q;
    mc_cmd_n_d       = mc_cmd_n_q;
    mc_rdnwr_d       = mc_rdnwr_q;
    mc_addr_d        = mc_addr_q;
    mc_data_in_vld_d = mc_data_in_vld_q;
    mc_data_in_d     = mc_data_in_q;
    rsp_vld_d        = 1'b0;
    rsp_rnw_d        = rsp_rnw_q;
    rsp_data_d       = rsp_data_q;
    fifo_pop         = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    rsp_err_d        = rsp_err_q;
    wait_cnt_d       = wait_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          req_rnw_d        = fifo_head.rnw;
          mc_cmd_n_d       = 1'b0;
          mc_rdnwr_d       = fifo_head.rnw;
          mc_addr_d        = fifo_head.addr;
          mc_data_in_vld_d = !fifo_head.rnw;
          if (!fifo_head.rnw) mc_data_in_d = fifo_head.wdata;
`ifdef MEM_REQ_TIMEOUT_EN
          wait_cnt_d       = '0;
`endif
          state_d          = StIssue;
        end
      end
      StIssue: begin
        if (cmd == CmdAct) begin
          mc_cmd_n_d = 1'b1;
          state_d    = req_rnw_q ? StRdWait : StWrWait;
        end
      end
      StWrWait: begin
        if (cmd == CmdWrite) begin
          mc_data_in_vld_d = 1'b0;
          rsp_vld_d        = 1'b1;
          rsp_rnw_d        = 1'b0;
          rsp_data_d       = '0;
          state_d          = StResp;
        end
      end
      StRdWait: begin
        if (mc_data_out_vld) state_d = StRdCapt;
      end
      // Data_out lags data_out_vld by one cycle in the controller.
      StRdCapt: begin
        rsp_vld_d  = 1'b1;
        rsp_rnw_d  = 1'b1;
        rsp_data_d = mc_data_out;
        state_d    = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef MEM_REQ_TIMEOUT_EN
    if (rsp_vld_d) rsp_err_d = 1'b0;
    if (state_q inside {StIssue, StWrWait, StRdWait}) begin
      if (wait_cnt_q == TimeoutLast) begin
        mc_cmd_n_d       = 1'b1;
        mc_data_in_vld_d = 1'b0;
        rsp_vld_d        = 1'b1;
        rsp_rnw_d        = req_rnw_q;
        rsp_data_d       = '0;
        rsp_err_d        = 1'b1;
        state_d          = StResp;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rdy_en_q         <= 1'b0;
      req_rnw_q        <= 1'b0;
      mc_cmd_n_q       <= 1'b1;
      mc_rdnwr_q       <= 1'b0;
      mc_addr_q        <= '0;
      mc_data_in_vld_q <= 1'b0;
      mc_data_in_q     <= '0;
      rsp_vld_q        <= 1'b0;
      rsp_rnw_q        <= 1'b0;
      rsp_data_q       <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      rsp_err_q        <= 1'b0;
      wait_cnt_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      rdy_en_q         <= 1'b1;
      req_rnw_q        <= req_rnw_d;
      mc_cmd_n_q       <= mc_cmd_n_d;
      mc_rdnwr_q       <= mc_rdnwr_d;
      mc_addr_q        <= mc_addr_d;
      mc_data_in_vld_q <= mc_data_in_vld_d;
      mc_data_in_q     <= mc_data_in_d;
      rsp_vld_q        <= rsp_vld_d;
      rsp_rnw_q        <= rsp_rnw_d;
      rsp_data_q       <= rsp_data_d;
`ifdef MEM_REQ_TIMEOUT_EN
      rsp_err_q        <= rsp_err_d;
      wait_cnt_q       <= wait_cnt_d;
`endif
    end
  end

  assign mc_cmd_n       = mc_cmd_n_q;
  assign mc_rdnwr       = mc_rdnwr_q;
  assign mc_addr        = mc_addr_q;
  assign mc_data_in_vld = mc_data_in_vld_q;
  assign mc_data_in     = mc_data_in_q;
  assign rsp_vld        = rsp_vld_q;
  assign rsp_rnw        = rsp_rnw_q;
  assign rsp_data       = rsp_data_q;
`ifdef MEM_REQ_TIMEOUT_EN
  assign rsp_err        = rsp_err_q;
`else
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched; the controller side is driven by hand, step by step.
module tb_mem_req_sched;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic        req_rnw;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rnw;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mc_cmd_n;
  logic        mc_rdnwr;
  logic [15:0] mc_addr;
  logic        mc_data_in_vld;
  logic [31:0] mc_data_in;
  logic [2:0]  mc_command;
  logic        mc_data_out_vld;
  logic [31:0] mc_data_out;

  int checks = 0;
  int errors = 0;

  mem_req_sched #(
    .DEPTH      (4),
    .AW         (16),
    .DW         (32),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_rnw        (req_rnw),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_vld        (rsp_vld),
    .rsp_rnw        (rsp_rnw),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .mc_cmd_n       (mc_cmd_n),
    .mc_rdnwr       (mc_rdnwr),
    .mc_addr        (mc_addr),
    .mc_data_in_vld (mc_data_in_vld),
    .mc_data_in     (mc_data_in),
    .mc_command     (mc_command),
    .mc_data_out_vld(mc_data_out_vld),
    .mc_data_out    (mc_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rnw, input logic [15:0] addr, input logic [31:0] wdata);
    req_vld   = 1'b1;
    req_rnw   = rnw;
    req_addr  = addr;
    req_wdata = wdata;
    chk("push_rdy", 64'(req_rdy), 64'd1);
    tick();
    req_vld = 1'b0;
  endtask

  // Waits (bounded) for an issued read, then plays ACT, data_out_vld and delayed Data_out.
  task automatic serve_read(input logic [15:0] addr, input logic [31:0] data);
    for (int n = 0; n < 16 && mc_cmd_n !== 1'b0; n++) tick();
    chk("rd_issue", 64'(mc_cmd_n), 64'd0);
    chk("rd_addr", 64'(mc_addr), 64'(addr));
    chk("rd_rdnwr", 64'(mc_rdnwr), 64'd1);
    mc_command = 3'd1;
    tick();
    mc_command      = 3'd0;
    mc_data_out_vld = 1'b1;
    mc_data_out     = ~data;
    tick();
    mc_data_out_vld = 1'b0;
    mc_data_out     = data;
    tick();
    chk("rd_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("rd_rsp_rnw", 64'(rsp_rnw), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'(data));
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    mc_data_out = '0;
    tick();
    chk("rd_rsp_pulse", 64'(rsp_vld), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    req_vld         = 1'b0;
    req_rnw         = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    mc_command      = 3'd0;
    mc_data_out_vld = 1'b0;
    mc_data_out     = '0;

    // Reset values
    repeat (2) tick();
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_cmd_n", 64'(mc_cmd_n), 64'd1);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_addr", 64'(mc_addr), 64'd0);
    chk("rst_din_vld", 64'(mc_data_in_vld), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", 64'(req_rdy), 64'd1);

    // Write 0x1234 <- 0xDEADBEEF
    push(1'b0, 16'h1234, 32'hDEADBEEF);
    chk("wr_no_bypass", 64'(mc_cmd_n), 64'd1);
    tick();
    chk("wr_cmd_n", 64'(mc_cmd_n), 64'd0);
    chk("wr_addr", 64'(mc_addr), 64'h1234);
    chk("wr_rdnwr", 64'(mc_rdnwr), 64'd0);
    chk("wr_din_vld", 64'(mc_data_in_vld), 64'd1);
    chk("wr_din", 64'(mc_data_in), 64'hDEADBEEF);
    repeat (2) tick();
    chk("wr_hold_cmd_n", 64'(mc_cmd_n), 64'd0);
    mc_command = 3'd1;
    tick();
    chk("wr_act_cmd_n", 64'(mc_cmd_n), 64'd1);
    chk("wr_act_din_vld", 64'(mc_data_in_vld), 64'd1);
    mc_command = 3'd0;
    tick();
    chk("wr_wait_din_vld", 64'(mc_data_in_vld), 64'd1);
    chk("wr_wait_addr", 64'(mc_addr), 64'h1234);
    chk("wr_wait_no_rsp", 64'(rsp_vld), 64'd0);
    mc_command = 3'd3;
    tick();
    chk("wr_done_din_vld", 64'(mc_data_in_vld), 64'd0);
    chk("wr_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("wr_rsp_rnw", 64'(rsp_rnw), 64'd0);
    chk("wr_rsp_data", 64'(rsp_data), 64'd0);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    mc_command = 3'd0;
    tick();
    chk("wr_rsp_pulse", 64'(rsp_vld), 64'd0);

    // Read 0x1234; garbage on Data_out during data_out_vld, real data one cycle later
    push(1'b1, 16'h1234, 32'h0);
    tick();
    chk("rd_cmd_n", 64'(mc_cmd_n), 64'd0);
    chk("rd_rdnwr", 64'(mc_rdnwr), 64'd1);
    chk("rd_din_vld", 64'(mc_data_in_vld), 64'd0);
    mc_command = 3'd1;
    tick();
    chk("rd_act_cmd_n", 64'(mc_cmd_n), 64'd1);
    mc_command      = 3'd0;
    mc_data_out_vld = 1'b1;
    mc_data_out     = 32'h0BADF00D;
    tick();
    chk("rd_capt_no_rsp", 64'(rsp_vld), 64'd0);
    mc_data_out_vld = 1'b0;
    mc_data_out     = 32'hDEADBEEF;
    tick();
    chk("rd_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("rd_rsp_rnw", 64'(rsp_rnw), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    mc_data_out = '0;
    tick();
    chk("rd_rsp_pulse", 64'(rsp_vld), 64'd0);

    // REFRESH during ISSUE does not advance
    push(1'b0, 16'h0ABC, 32'hCAFEF00D);
    tick();
    mc_command = 3'd5;
    tick();
    chk("ref_cmd_n", 64'(mc_cmd_n), 64'd0);
    chk("ref_addr", 64'(mc_addr), 64'h0ABC);
    tick();
    chk("ref_cmd_n2", 64'(mc_cmd_n), 64'd0);
    chk("ref_addr2", 64'(mc_addr), 64'h0ABC);
    mc_command = 3'd1;
    tick();
    chk("ref_act_cmd_n", 64'(mc_cmd_n), 64'd1);
    mc_command = 3'd3;
    tick();
    chk("ref_rsp_vld", 64'(rsp_vld), 64'd1);
    mc_command = 3'd0;
    tick();

    // Back-to-back burst with a stalled controller: first issues, next four fill the FIFO
    for (int i = 0; i < 5; i++) begin
      req_vld  = 1'b1;
      req_rnw  = 1'b1;
      req_addr = 16'h0100 + 16'(i);
      chk("burst_rdy", 64'(req_rdy), 64'd1);
      tick();
    end
    chk("burst_full", 64'(req_rdy), 64'd0);
    req_addr = 16'h0105;
    repeat (3) tick();
    chk("burst_stall_rdy", 64'(req_rdy), 64'd0);
    chk("burst_head_addr", 64'(mc_addr), 64'h0100);
    serve_read(16'h0100, 32'hA5000000);
    chk("burst_still_full", 64'(req_rdy), 64'd0);
    tick();
    chk("burst_pop_rdy", 64'(req_rdy), 64'd1);
    chk("burst_next_addr", 64'(mc_addr), 64'h0101);
    tick();
    req_vld = 1'b0;
    chk("burst_refull", 64'(req_rdy), 64'd0);
    for (int i = 1; i < 6; i++) begin
      serve_read(16'h0100 + 16'(i), 32'hA5000000 + 32'(i));
    end

    // Reset during RD_WAIT with a second request still queued
    push(1'b1, 16'h2222, 32'h0);
    req_vld  = 1'b1;
    req_rnw  = 1'b1;
    req_addr = 16'h3333;
    tick();
    req_vld    = 1'b0;
    mc_command = 3'd1;
    tick();
    mc_command = 3'd0;
    rst_n      = 1'b0;
    #1;
    chk("mid_rst_cmd_n", 64'(mc_cmd_n), 64'd1);
    chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
    chk("mid_rst_addr", 64'(mc_addr), 64'd0);
    chk("mid_rst_rsp", 64'(rsp_vld), 64'd0);
    repeat (2) tick();
    chk("mid_rst_rsp2", 64'(rsp_vld), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("after_rst_rdy", 64'(req_rdy), 64'd1);
    repeat (3) tick();
    chk("flushed_cmd_n", 64'(mc_cmd_n), 64'd1);
    chk("flushed_rsp", 64'(rsp_vld), 64'd0);
    push(1'b1, 16'h4444, 32'h0);
    serve_read(16'h4444, 32'h5A5A5A5A);

`ifdef MEM_REQ_TIMEOUT_EN
    // Controller never answers ACT: abort after 64 waiting cycles, then the next one issues
    push(1'b0, 16'h7777, 32'h12345678);
    push(1'b1, 16'h8888, 32'h0);
    chk("to_cmd_n", 64'(mc_cmd_n), 64'd0);
    chk("to_addr", 64'(mc_addr), 64'h7777);
    repeat (63) tick();
    chk("to_not_yet", 64'(rsp_vld), 64'd0);
    chk("to_not_yet_cmd_n", 64'(mc_cmd_n), 64'd0);
    tick();
    chk("to_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_data", 64'(rsp_data), 64'd0);
    chk("to_cmd_n_hi", 64'(mc_cmd_n), 64'd1);
    chk("to_din_vld", 64'(mc_data_in_vld), 64'd0);
    tick();
    chk("to_rsp_pulse", 64'(rsp_vld), 64'd0);
    serve_read(16'h8888, 32'h0F0F0F0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
